// File: rtl/note_lane_scorer.sv
// Rhythm-game lane engine: scrolls one note per lane, scores edge-detected button
// presses inside the hit window, tracks combo/miss statistics and draws notes/zone.
module note_lane_scorer #(
    parameter int LANES       = 4,
    parameter int SCROLL_DIV  = 500000,
    parameter int WRAP_Y      = 779,
    parameter int HIT_TOP     = 400,
    parameter int HIT_BOT     = 475,
    parameter int LANE_X0     = 200,
    parameter int LANE_PITCH  = 120,
    parameter int LANE_W      = 40,
    parameter int NOTE_H      = 40,
    parameter int LANE_Y_STEP = 120,
    parameter int POINTS      = 1,
    parameter int COMBO_TH    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LANES-1:0]     buttons,
    input  logic [9:0]           hCount,
    input  logic [9:0]           vCount,
    output logic                 note_on,
    output logic                 zone_on,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo,
    output logic [15:0]          misses,
    output logic [2*LANES-1:0]   lane_state
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'b00,
        ST_HIT    = 2'b01,
        ST_MISSED = 2'b10
    } lane_st_t;

    localparam int                TICK_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_DIV - 1);
    localparam logic [9:0]        Y_WRAP    = 10'(WRAP_Y);
    localparam logic [9:0]        Y_TOP     = 10'(HIT_TOP);
    localparam logic [9:0]        Y_BOT     = 10'(HIT_BOT);

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'h0000_00FF) ? 8'hFF : v[7:0];
    endfunction

    logic [TICK_W-1:0] r_tick;
    logic [9:0]        r_y [LANES];
    lane_st_t          r_st [LANES];
    logic [LANES-1:0]  r_btn_prev;
    logic [15:0]       r_score;
    logic [15:0]       r_misses;
    logic [7:0]        r_combo;
    logic [7:0]        r_max;

    logic              w_adv;
    logic [LANES-1:0]  w_press;
    logic [LANES-1:0]  w_hit;
    logic [LANES-1:0]  w_ghost;
    logic [LANES-1:0]  w_miss;
    logic [LANES-1:0]  w_in_lane;
    logic [9:0]        w_y_nxt [LANES];
    lane_st_t          w_st_nxt [LANES];
    logic [3:0]        w_n_hit;
    logic [3:0]        w_n_miss;
    logic [31:0]       w_pts;
    logic [15:0]       w_score_nxt;
    logic [15:0]       w_misses_nxt;
    logic [7:0]        w_combo_nxt;

    assign w_adv   = (r_tick == TICK_LAST);
    assign w_press = buttons & ~r_btn_prev;

    // Presses are judged against the pre-advance Y; a hit on the last window line
    // therefore suppresses the miss that the same-cycle advance would raise.
    always_comb begin
        w_hit    = '0;
        w_ghost  = '0;
        w_miss   = '0;
        w_n_hit  = '0;
        w_n_miss = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hit[i]   = w_press[i] && (r_st[i] == ST_ARMED) && (r_y[i] >= Y_TOP) && (r_y[i] <= Y_BOT);
            w_ghost[i] = w_press[i] && !w_hit[i];
            w_miss[i]  = w_adv && (r_st[i] == ST_ARMED) && (r_y[i] == Y_BOT) && !w_hit[i];
            w_n_hit    = w_n_hit + 4'(w_hit[i]);
            w_n_miss   = w_n_miss + 4'(w_miss[i]);

            w_y_nxt[i]  = r_y[i];
            w_st_nxt[i] = r_st[i];
            if (w_adv && (r_y[i] == Y_WRAP)) begin
                w_y_nxt[i]  = '0;
                w_st_nxt[i] = ST_ARMED;
            end else begin
                if (w_adv) begin
                    w_y_nxt[i] = r_y[i] + 10'd1;
                end
                if (w_hit[i]) begin
                    w_st_nxt[i] = ST_HIT;
                end else if (w_miss[i]) begin
                    w_st_nxt[i] = ST_MISSED;
                end
            end
        end

        w_pts        = ({24'b0, r_combo} >= 32'(COMBO_TH)) ? 32'(2 * POINTS) : 32'(POINTS);
        w_score_nxt  = sat16({16'b0, r_score} + ({28'b0, w_n_hit} * w_pts));
        w_misses_nxt = sat16({16'b0, r_misses} + {28'b0, w_n_miss});
        w_combo_nxt  = ((|w_miss) || (|w_ghost)) ? 8'd0 : sat8({24'b0, r_combo} + {28'b0, w_n_hit});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick     <= '0;
            r_btn_prev <= '0;
            r_score    <= '0;
            r_misses   <= '0;
            r_combo    <= '0;
            r_max      <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_y[i]  <= 10'((i * LANE_Y_STEP) % WRAP_Y);
                r_st[i] <= ST_ARMED;
            end
        end else begin
            r_tick     <= w_adv ? '0 : r_tick + TICK_W'(1);
            r_btn_prev <= buttons;
            r_score    <= w_score_nxt;
            r_misses   <= w_misses_nxt;
            r_combo    <= w_combo_nxt;
            if (r_combo > r_max) begin
                r_max <= r_combo;
            end
            for (int i = 0; i < LANES; i++) begin
                r_y[i]  <= w_y_nxt[i];
                r_st[i] <= w_st_nxt[i];
            end
        end
    end

    // Note bottom is computed in 11 bits so a note near the wrap line never folds back.
    always_comb begin
        note_on    = 1'b0;
        lane_state = '0;
        w_in_lane  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_in_lane[i] = ({2'b00, hCount} >= 12'(LANE_X0 + i * LANE_PITCH)) &&
                           ({2'b00, hCount} <  12'(LANE_X0 + i * LANE_PITCH + LANE_W));
            if (w_in_lane[i] && ({1'b0, vCount} >= {1'b0, r_y[i]}) &&
                ({1'b0, vCount} <= ({1'b0, r_y[i]} + 11'(NOTE_H)))) begin
                note_on = 1'b1;
            end
            lane_state[2*i +: 2] = r_st[i];
        end
        zone_on = (|w_in_lane) && (vCount >= Y_TOP) && (vCount <= Y_BOT);
    end

    assign score     = r_score;
    assign combo     = r_combo;
    assign max_combo = r_max;
    assign misses    = r_misses;

endmodule
